// File: rtl/m72_video_timing_gen.sv
// Programmable H/V raster generator: runtime-configurable totals, blanking, sync and raster IRQ.
// Optional build macro VTG_SHADOW_EN: config writes are staged and applied atomically at frame end.
module m72_video_timing_gen #(
  parameter int HW = 10,
  parameter int VW = 9
) (
  input  logic          CLK_32M,
  input  logic          RESET_N,
  input  logic          CE_PIX,
  input  logic          NL,
  input  logic          CFG_WE,
  input  logic [3:0]    CFG_ADDR,
  input  logic [15:0]   CFG_DATA,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic [HW-1:0] HE,
  output logic [VW-1:0] VE,
  output logic          CLD,
  output logic          FRAME_END,
  output logic          HBLK,
  output logic          VBLK,
  output logic          CPBLK,
  output logic          HS,
  output logic          VS,
  output logic          HINT
);

  typedef struct packed {
    logic [HW-1:0] h_start;
    logic [HW-1:0] h_end;
    logic [HW-1:0] hb_on;
    logic [HW-1:0] hb_off;
    logic [HW-1:0] hs_on;
    logic [HW-1:0] hs_off;
    logic [VW-1:0] v_start;
    logic [VW-1:0] v_end;
    logic [VW-1:0] vb_on;
    logic [VW-1:0] vb_off;
    logic [VW-1:0] vs_on;
    logic [VW-1:0] vs_off;
    logic [VW-1:0] int_line;
    logic [HW-1:0] int_hpos;
  } cfg_t;

  // Power-on raster: 512 clk x 284 lines, 384x256 active.
  function automatic cfg_t cfg_default();
    cfg_t c;
    c.h_start  = HW'(16'h100);
    c.h_end    = HW'(16'h2FF);
    c.hb_on    = HW'(16'h2C0);
    c.hb_off   = HW'(16'h140);
    c.hs_on    = HW'(16'h2D0);
    c.hs_off   = HW'(16'h2F8);
    c.v_start  = VW'(16'h072);
    c.v_end    = VW'(16'h18D);
    c.vb_on    = VW'(16'h180);
    c.vb_off   = VW'(16'h080);
    c.vs_on    = VW'(16'h184);
    c.vs_off   = VW'(16'h18A);
    c.int_line = VW'(16'h1FF);
    c.int_hpos = HW'(16'h100);
    return c;
  endfunction

  function automatic cfg_t cfg_apply(input cfg_t c, input logic [3:0] addr,
                                     input logic [15:0] data);
    cfg_t r;
    r = c;
    case (addr)
      4'd0:    r.h_start  = data[HW-1:0];
      4'd1:    r.h_end    = data[HW-1:0];
      4'd2:    r.hb_on    = data[HW-1:0];
      4'd3:    r.hb_off   = data[HW-1:0];
      4'd4:    r.hs_on    = data[HW-1:0];
      4'd5:    r.hs_off   = data[HW-1:0];
      4'd6:    r.v_start  = data[VW-1:0];
      4'd7:    r.v_end    = data[VW-1:0];
      4'd8:    r.vb_on    = data[VW-1:0];
      4'd9:    r.vb_off   = data[VW-1:0];
      4'd10:   r.vs_on    = data[VW-1:0];
      4'd11:   r.vs_off   = data[VW-1:0];
      4'd12:   r.int_line = data[VW-1:0];
      4'd13:   r.int_hpos = data[HW-1:0];
      default: ;
    endcase
    return r;
  endfunction

  // Set has priority so ON==OFF latches the active state.
  function automatic logic set_clr(input logic cur, input logic set, input logic clr);
    if (set)      return 1'b1;
    else if (clr) return 1'b0;
    else          return cur;
  endfunction

  cfg_t          live;
  logic [VW-1:0] v_next;
  logic          unused_cfg_bits;

  assign unused_cfg_bits = ^CFG_DATA[15:HW];

`ifdef VTG_SHADOW_EN
  cfg_t shadow;

  // Live copy is taken from the pre-write shadow, so a same-cycle write waits a frame.
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow <= cfg_default();
      live   <= cfg_default();
    end else begin
      if (CFG_WE)
        shadow <= cfg_apply(shadow, CFG_ADDR, CFG_DATA);
      if (CE_PIX && FRAME_END)
        live <= shadow;
    end
  end
`else
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N)
      live <= cfg_default();
    else if (CFG_WE)
      live <= cfg_apply(live, CFG_ADDR, CFG_DATA);
  end
`endif

  assign HE        = H ^ {HW{NL}};
  assign VE        = V ^ {VW{NL}};
  assign CLD       = (H >= live.h_end);
  assign FRAME_END = CLD && (V >= live.v_end);
  assign CPBLK     = HBLK | VBLK;
  assign v_next    = FRAME_END ? live.v_start : V + VW'(1);

  // Vertical flags track the line V is about to enter, so they update on the line-end CE only.
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      H    <= HW'(16'h100);
      V    <= VW'(16'h072);
      HBLK <= 1'b1;
      VBLK <= 1'b1;
      HS   <= 1'b1;
      VS   <= 1'b1;
      HINT <= 1'b0;
    end else if (CE_PIX) begin
      if (CLD) begin
        H <= live.h_start;
        V <= v_next;
        VBLK <= set_clr(VBLK, v_next == live.vb_on, v_next == live.vb_off);
        VS   <= ~set_clr(~VS, v_next == live.vs_on, v_next == live.vs_off);
      end else begin
        H <= H + HW'(1);
      end
      HBLK <= set_clr(HBLK, H == live.hb_on, H == live.hb_off);
      HS   <= ~set_clr(~HS, H == live.hs_on, H == live.hs_off);
      HINT <= (VE == live.int_line) && (H == live.int_hpos);
    end
  end

endmodule

// File: tb/tb_m72_video_timing_gen.sv
// Directed bench for m72_video_timing_gen: raster periods, blank/sync windows, raster IRQ, config and reset.
module tb_m72_video_timing_gen;

  logic        CLK_32M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CE_PIX  = 1'b0;
  logic        NL      = 1'b0;
  logic        CFG_WE  = 1'b0;
  logic [3:0]  CFG_ADDR = 4'd0;
  logic [15:0] CFG_DATA = 16'd0;
  logic [9:0]  H, HE;
  logic [8:0]  V, VE;
  logic        CLD, FRAME_END, HBLK, VBLK, CPBLK, HS, VS, irq_o;

  int nvec = 0;
  int nerr = 0;
  int ce_gap = 3;

  m72_video_timing_gen #(.HW(10), .VW(9)) dut (
    .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .NL(NL),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .H(H), .V(V), .HE(HE), .VE(VE), .CLD(CLD), .FRAME_END(FRAME_END),
    .HBLK(HBLK), .VBLK(VBLK), .CPBLK(CPBLK), .HS(HS), .VS(VS), .HINT(irq_o)
  );

  always #5 CLK_32M = ~CLK_32M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    CE_PIX = 1'b1;
    @(posedge CLK_32M); #1;
    CE_PIX = 1'b0;
    repeat (ce_gap) begin
      @(posedge CLK_32M); #1;
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [15:0] d);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_DATA = d;
    @(posedge CLK_32M); #1;
    CFG_WE = 1'b0;
  endtask

  task automatic run_until_cld(output int n);
    n = 0;
    do begin step(); n++; end while (!CLD && n < 4000);
  endtask

  task automatic run_until_fe(output int n);
    n = 0;
    do begin step(); n++; end while (!FRAME_END && n < 12000);
  endtask

  task automatic run_until_h(input logic [9:0] target);
    int n;
    n = 0;
    do begin step(); n++; end while (H != target && n < 2000);
  endtask

  task automatic hint_frame(output int pulses, output logic [8:0] pv, output logic [9:0] ph);
    pulses = 0; pv = '0; ph = '0;
    for (int i = 0; i < 2560; i++) begin
      step();
      if (irq_o) begin pulses++; pv = V; ph = H; end
    end
  endtask

  initial begin
    int n, lo_a, lo_b, pulses;
    logic [8:0] pv;
    logic [9:0] ph;

    // Reset state
    #12;
    chk("rst_h", H, 32'h100);
    chk("rst_v", V, 32'h072);
    chk("rst_he", HE, 32'h100);
    chk("rst_ve", VE, 32'h072);
    chk("rst_hblk", HBLK, 1);
    chk("rst_vblk", VBLK, 1);
    chk("rst_cpblk", CPBLK, 1);
    chk("rst_hs", HS, 1);
    chk("rst_vs", VS, 1);
    chk("rst_hint", irq_o, 0);
    chk("rst_cld", CLD, 0);
    chk("rst_fe", FRAME_END, 0);
    @(posedge CLK_32M); #1;
    RESET_N = 1'b1;

    // Line period with CE every 4th clock
    run_until_cld(n);
    chk("first_line_ce", n, 511);
    run_until_cld(n);
    chk("line_period", n, 512);
    chk("v_after_line", V, 32'h073);
    step();
    chk("h_restart", H, 32'h100);
    chk("v_incr", V, 32'h074);

    // Blank and sync windows with continuous CE
    ce_gap = 0;
    run_until_h(10'h2D0);
    chk("hs_pre_h", H, 32'h2D0);
    chk("hs_pre", HS, 1);
    step();
    chk("hs_latency", HS, 0);
    lo_a = 0; lo_b = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (!HBLK) lo_a++;
      if (!HS) lo_b++;
    end
    chk("hblk_low_ce", lo_a, 384);
    chk("hs_low_ce", lo_b, 40);
    chk("vblk_top", VBLK, 1);

    // Short frame 0x07E..0x082 for frame-end checks
    cfg(4'd6, 16'h007E);
    cfg(4'd7, 16'h0082);
    run_until_fe(n);
    chk("fe_reached", FRAME_END, 1);
    step();
    chk("fe_v_restart", V, 32'h07E);
    chk("fe_h_restart", H, 32'h100);
    chk("vblk_cleared", VBLK, 0);
    chk("cpblk_hblk_on", CPBLK, 1);
    run_until_h(10'h200);
    chk("cpblk_active", CPBLK, 0);
    run_until_fe(n);
    run_until_fe(n);
    chk("frame_period", n, 2560);

    // Raster IRQ, NL=0
    cfg(4'd6, 16'h009E);
    step();
    chk("hint_v_start", V, 32'h09E);
    cfg(4'd7, 16'h00A2);
    cfg(4'd12, 16'h00A0);
    hint_frame(pulses, pv, ph);
    chk("hint_count", pulses, 1);
    chk("hint_v", pv, 32'h0A0);
    chk("hint_h", ph, 32'h101);

    // Raster IRQ with flip
    cfg(4'd6, 16'h015D);
    run_until_fe(n);
    step();
    chk("nl_v_start", V, 32'h15D);
    cfg(4'd7, 16'h0161);
    NL = 1'b1;
    #1;
    chk("nl_he", HE, 32'h2FF);
    chk("nl_ve", VE, 32'h0A2);
    hint_frame(pulses, pv, ph);
    chk("nl_hint_count", pulses, 1);
    chk("nl_hint_v", pv, 32'h15F);
    chk("nl_hint_h", ph, 32'h101);
    NL = 1'b0;
    hint_frame(pulses, pv, ph);
    chk("no_hint_count", pulses, 0);

    // Mid-line H_END reduction
    run_until_h(10'h290);
    chk("hend_pre_h", H, 32'h290);
    chk("hend_pre_cld", CLD, 0);
    cfg(4'd1, 16'h027F);
    chk("hend_cld_now", CLD, 1);
    step();
    chk("hend_wrap", H, 32'h100);
    run_until_cld(n);
    chk("hend_first", n, 383);
    run_until_cld(n);
    chk("hend_period", n, 384);

    // Ignored address 15
    cfg(4'd15, 16'hFFFF);
    chk("a15_h", H, 32'h27F);
    chk("a15_cld", CLD, 1);
    step();
    chk("a15_h_restart", H, 32'h100);
    run_until_cld(n);
    chk("a15_period", n, 383);

    // HB_ON == HB_OFF: set wins
    cfg(4'd2, 16'h0200);
    cfg(4'd3, 16'h0200);
    run_until_h(10'h201);
    chk("hb_eq_set", HBLK, 1);
    lo_a = 0;
    for (int i = 0; i < 384; i++) begin
      step();
      if (!HBLK) lo_a++;
    end
    chk("hb_eq_stays", lo_a, 0);

    // Asynchronous reset between clock edges
    run_until_h(10'h180);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_h", H, 32'h100);
    chk("arst_v", V, 32'h072);
    chk("arst_hblk", HBLK, 1);
    chk("arst_vblk", VBLK, 1);
    chk("arst_hs", HS, 1);
    chk("arst_hint", irq_o, 0);
    #2 RESET_N = 1'b1;
    step();
    chk("arst_first_ce", H, 32'h101);
    run_until_cld(n);
    chk("arst_hend_default", n, 510);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
